// File: rtl/hazard_stall_ctrl.sv
// Stall/flush controller for the 5-stage MIPS pipeline: Tuse/Tnew data hazards,
// mult/div busy tracking and a stall-cycle performance counter.
module hazard_stall_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10,
  parameter int CNT_W       = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] D_Inst,
  input  logic [31:0] E_Inst,
  input  logic [31:0] M_Inst,
  output logic        PC_en,
  output logic        IF_ID_en,
  output logic        ID_EX_clr,
  output logic        stall,
  output logic        md_start,
  output logic        md_busy,
  output logic [31:0] stall_cnt
);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ORI   = 6'h0d;
  localparam logic [5:0] OP_LUI   = 6'h0f;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;

  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_MFHI  = 6'h10;
  localparam logic [5:0] FN_MTHI  = 6'h11;
  localparam logic [5:0] FN_MFLO  = 6'h12;
  localparam logic [5:0] FN_MTLO  = 6'h13;
  localparam logic [5:0] FN_MULT  = 6'h18;
  localparam logic [5:0] FN_MULTU = 6'h19;
  localparam logic [5:0] FN_DIV   = 6'h1a;
  localparam logic [5:0] FN_DIVU  = 6'h1b;
  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUBU  = 6'h23;

  // A Tuse of 3 marks an unread source: no Tnew is ever large enough to beat it.
  localparam logic [1:0] T_NONE = 2'd3;

  typedef struct packed {
    logic [1:0] rs;
    logic [1:0] rt;
  } tuse_t;

  typedef struct packed {
    logic [4:0] dst;
    logic [1:0] tnew;
  } prod_t;

  function automatic tuse_t src_tuse(input logic [31:0] inst);
    tuse_t t;
    t.rs = T_NONE;
    t.rt = T_NONE;
    case (inst[31:26])
      OP_BEQ: begin
        t.rs = 2'd0;
        t.rt = 2'd0;
      end
      OP_ORI, OP_LW: t.rs = 2'd1;
      OP_SW: begin
        t.rs = 2'd1;
        t.rt = 2'd2;
      end
      OP_RTYPE: begin
        case (inst[5:0])
          FN_JR: t.rs = 2'd0;
          FN_ADDU, FN_SUBU, FN_MULT, FN_MULTU, FN_DIV, FN_DIVU: begin
            t.rs = 2'd1;
            t.rt = 2'd1;
          end
          FN_MTHI, FN_MTLO: t.rs = 2'd1;
          default: ;
        endcase
      end
      default: ;
    endcase
    return t;
  endfunction

  function automatic prod_t producer(input logic [31:0] inst);
    prod_t p;
    p.dst  = 5'd0;
    p.tnew = 2'd0;
    case (inst[31:26])
      OP_ORI, OP_LUI: begin
        p.dst  = inst[20:16];
        p.tnew = 2'd1;
      end
      OP_LW: begin
        p.dst  = inst[20:16];
        p.tnew = 2'd2;
      end
      OP_JAL: begin
        p.dst  = 5'd31;
        p.tnew = 2'd0;
      end
      OP_RTYPE: begin
        case (inst[5:0])
          FN_ADDU, FN_SUBU, FN_MFHI, FN_MFLO: begin
            p.dst  = inst[15:11];
            p.tnew = 2'd1;
          end
          default: ;
        endcase
      end
      default: ;
    endcase
    return p;
  endfunction

  function automatic logic is_md_op(input logic [31:0] inst);
    return (inst[31:26] == OP_RTYPE) &&
           (inst[5:0] inside {FN_MULT, FN_MULTU, FN_DIV, FN_DIVU});
  endfunction

  function automatic logic is_md_user(input logic [31:0] inst);
    return (inst[31:26] == OP_RTYPE) &&
           (inst[5:0] inside {FN_MULT, FN_MULTU, FN_DIV, FN_DIVU,
                              FN_MFHI, FN_MFLO, FN_MTHI, FN_MTLO});
  endfunction

  logic [4:0]       d_rs;
  logic [4:0]       d_rt;
  tuse_t            d_use;
  prod_t            prod [2];
  logic [1:0]       stage_hz;
  logic             data_hz;
  logic             md_hz;
  logic             e_is_div;
  logic [CNT_W-1:0] busy_q;
  logic [CNT_W-1:0] busy_d;
  logic [31:0]      stall_cnt_q;
  logic [31:0]      stall_cnt_d;
  logic             unused_fields;

  assign d_rs    = D_Inst[25:21];
  assign d_rt    = D_Inst[20:16];
  assign d_use   = src_tuse(D_Inst);
  assign prod[0] = producer(E_Inst);
  assign prod[1] = producer(M_Inst);

  // Stage 0 is EX, stage 1 is MEM; a producer is one cycle closer to ready in MEM.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_stage
      logic [1:0] tnew_now;
      assign tnew_now = (gi == 0) ? prod[gi].tnew :
                        ((prod[gi].tnew == 2'd0) ? 2'd0 : prod[gi].tnew - 2'd1);
      assign stage_hz[gi] =
          ((d_rs != 5'd0) && (d_rs == prod[gi].dst) && (d_use.rs < tnew_now)) ||
          ((d_rt != 5'd0) && (d_rt == prod[gi].dst) && (d_use.rt < tnew_now));
    end
  endgenerate

  assign data_hz   = |stage_hz;
  assign md_start  = is_md_op(E_Inst);
  assign e_is_div  = (E_Inst[5:0] == FN_DIV) || (E_Inst[5:0] == FN_DIVU);
  assign md_busy   = md_start || (busy_q != '0);
  assign md_hz     = is_md_user(D_Inst) && md_busy;
  assign stall     = data_hz || md_hz;
  assign PC_en     = ~stall;
  assign IF_ID_en  = ~stall;
  assign ID_EX_clr = stall;
  assign stall_cnt = stall_cnt_q;

  assign unused_fields = ^{D_Inst[15:6], E_Inst[25:21], E_Inst[10:6],
                           M_Inst[25:21], M_Inst[10:6]};

  always_comb begin
    busy_d = busy_q;
    if (md_start) begin
      busy_d = e_is_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
    end else if (busy_q != '0) begin
      busy_d = busy_q - CNT_W'(1);
    end
  end

  assign stall_cnt_d = stall ? stall_cnt_q + 32'd1 : stall_cnt_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy_q      <= '0;
      stall_cnt_q <= '0;
    end else begin
      busy_q      <= busy_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

endmodule
